// File: rtl/lu_serial_seq.sv
// Bit-serial sequencer that applies a 1-bit AND/NAND/OR/NOR cell to WIDTH-bit
// operands, LSB first, with valid/ready handshakes on both request and result.
module lu_serial_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic sel_group, sel_gate, cell_out;

  // The shared logic cell: group picks AND vs OR, gate inverts the result.
  assign sel_group = ~op_q[1];
  assign sel_gate  = op_q[0];
  assign cell_out  = (sel_group ? (a_q[0] & b_q[0]) : (a_q[0] | b_q[0])) ^ sel_gate;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)           state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST_BIT)  state_d = S_DONE;
      S_DONE:  if (out_ready)          state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_RUN:   busy      = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch on accept, shift one bit per cycle in RUN, hold otherwise.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          result_d = '0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        result_d = {cell_out, result_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_lu_serial_seq.sv
// Directed self-checking bench for lu_serial_seq: table of ops plus
// hand-written backpressure, disturbance and mid-operation reset sequences.
module tb_lu_serial_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[4];

  lu_serial_seq #(.WIDTH(WIDTH), .CW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances until out_valid rises, bounded; returns the cycle count.
  task automatic wait_done(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!out_valid && k < 40);
  endtask

  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [1:0] vop,
                        input logic [7:0] exp, input string nm);
    int k;
    check({nm, " in_ready before accept"}, 32'(in_ready), 32'd1);
    a = va; b = vb; op = vop; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({nm, " busy after accept"}, 32'(busy), 32'd1);
    check({nm, " result cleared on accept"}, 32'(result), 32'd0);
    wait_done(k);
    check({nm, " latency"}, 32'(k), 32'(WIDTH));
    check({nm, " result"}, 32'(result), 32'(exp));
    tick();
    check({nm, " out_valid after pop"}, 32'(out_valid), 32'd0);
    check({nm, " in_ready after pop"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int k;

    vecs[0] = '{8'hCA, 8'h5C, 2'b00, 8'h48, "AND"};
    vecs[1] = '{8'hCA, 8'h5C, 2'b01, 8'hB7, "NAND"};
    vecs[2] = '{8'hCA, 8'h5C, 2'b10, 8'hDE, "OR"};
    vecs[3] = '{8'hCA, 8'h5C, 2'b11, 8'h21, "NOR"};

    // Reset with in_valid high: reset must win and nothing is latched.
    rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 2'b00; out_ready = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset result", 32'(result), 32'd0);
    rst = 1'b0;
    tick();
    check("idle after reset busy", 32'(busy), 32'd0);

    // Back-to-back ops, out_ready held high.
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].name);
    end

    // Backpressure: result held in DONE, new request refused until popped.
    out_ready = 1'b0;
    a = 8'hFF; b = 8'h00; op = 2'b11; in_valid = 1'b1;
    tick();
    a = 8'h0F; b = 8'hFF; op = 2'b00;
    wait_done(k);
    check("bp latency", 32'(k), 32'(WIDTH));
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid held", 32'(out_valid), 32'd1);
      check("bp result held", 32'(result), 32'h00);
      check("bp in_ready low", 32'(in_ready), 32'd0);
      check("bp busy low", 32'(busy), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp out_valid after pop", 32'(out_valid), 32'd0);
    check("bp in_ready after pop", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp second accept busy", 32'(busy), 32'd1);
    wait_done(k);
    check("bp second latency", 32'(k), 32'(WIDTH));
    check("bp second result", 32'(result), 32'h0F);
    tick();

    // Input disturbance during RUN is ignored; out_ready high before DONE too.
    a = 8'hF0; b = 8'h0F; op = 2'b10; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    k = 0;
    while (!out_valid && k < 40) begin
      a = ~a; b = b + 8'h33; op = op + 2'd1; in_valid = ~in_valid;
      tick();
      k++;
    end
    in_valid = 1'b0;
    check("disturb latency", 32'(k), 32'(WIDTH));
    check("disturb result", 32'(result), 32'hFF);
    tick();
    check("disturb in_ready after pop", 32'(in_ready), 32'd1);

    // Mid-operation reset at RUN count 4.
    a = 8'hCA; b = 8'h5C; op = 2'b10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("midrst busy before reset", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst result", 32'(result), 32'd0);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) k++;
      tick();
    end
    check("midrst out_valid never pulses", 32'(k), 32'd0);
    run_op(8'hCA, 8'h5C, 2'b01, 8'hB7, "after midrst NAND");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lu_serial_seq.md
Name: lu_serial_seq

Overview:
- Bit-serial sequencer that drives the team's 1-bit four-function logic cell (AND/NAND/OR/NOR, controlled by sel_gate/sel_group) over WIDTH-bit operands.
- Accepts one operation per valid/ready handshake and processes one bit per clock, LSB first.
- Assembles the WIDTH-bit result in a shift register and presents it on an output valid/ready handshake.
- Sits between the register file/operand source and result sink, time-sharing a single logic cell.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CW, 4, counter width; must satisfy 2^CW > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand/op request valid
in_ready  output  1  block can accept a request
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  2  00 AND, 01 NAND, 10 OR, 11 NOR
out_valid  output  1  result available
out_ready  input  1  sink accepts result
result  output  WIDTH  assembled result
busy  output  1  high in RUN state

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); the polarity and synchronicity here are fixed.
- Reset, including mid-operation: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0, latched operands/op=0.
- Cell mapping from latched op: sel_group = ~op[1] (1 selects the AND/NAND group), sel_gate = op[0] (1 selects the inverted gate). Cell inputs are a_reg[0], b_reg[0].
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b, op; clear the result register and counter; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge:
    - result <= {cell_out, result[WIDTH-1:1]};
    - a_reg <= a_reg>>1; b_reg <= b_reg>>1;
    - counter <= counter+1.
  - When counter==WIDTH-1 at an edge, that edge performs the final shift and moves to DONE.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - result holds stable until the edge where out_ready=1, which then moves to IDLE.
  - out_valid drops in the cycle after that edge.
- Latency: accept at edge T0, out_valid high after edge T0+WIDTH (exactly WIDTH cycles). Minimum issue interval is WIDTH+2 cycles with out_ready held high.
- Bit i of result equals op(a[i], b[i]) after completion.
- While in RUN or DONE:
  - changes on a, b, op and in_valid are ignored;
  - out_ready asserted before DONE is ignored.
- No accept in the same cycle as a result pop; in_ready rises the cycle after the DONE->IDLE transition.
- During IDLE and RUN, result shows the register contents (0 after reset or accept, partial while RUN). The sink must qualify result with out_valid.
- If rst and in_valid are both high at an edge, reset wins and nothing is latched.
- Outputs in_ready, out_valid and busy are decoded from registered state only; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: rst=1 for 2 cycles -> in_ready=1, out_valid=0, busy=0, result=0x00.
- WIDTH=8, a=0xCA, b=0x5C, op=00, out_ready=1 -> out_valid exactly 8 cycles after accept, result=0x48.
- Same operands with op=01/10/11 -> result=0xB7 / 0xDE / 0x21; each issued back-to-back, in_ready re-asserts 1 cycle after each pop.
- Backpressure: out_ready=0 for 5 cycles in DONE (a=0xFF, b=0x00, op=11, expect 0x00) -> out_valid and result stable, in_ready=0, and a new in_valid with a=0x0F is not accepted; raise out_ready -> pop, then accept.
- Input disturbance: after accepting a=0xF0, b=0x0F, op=10, toggle a/b/op every cycle during RUN -> result=0xFF.
- Mid-operation reset: assert rst at RUN count 4 -> next cycle IDLE, result=0x00, out_valid never pulses; a subsequent op completes correctly.
